// File: rtl/bp_fe_fetch_buffer.sv
// Fetch decoupling FIFO between the I$ TV stage and the FE queue, with wait/run/drain control.
// Define BP_FE_FETCH_BUFFER_BYPASS_EN to forward an enqueue straight to the head when empty.
module bp_fe_fetch_buffer #(
   parameter int vaddr_width_p    = 39,
   parameter int instr_width_p    = 32,
   parameter int meta_width_p     = 36,
   parameter int exc_code_width_p = 2,
   parameter int els_p            = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          redirect_v_i,
   input  logic                          fetch_v_i,
   output logic                          fetch_ready_o,
   input  logic [vaddr_width_p-1:0]      fetch_pc_i,
   input  logic [instr_width_p-1:0]      fetch_instr_i,
   input  logic [meta_width_p-1:0]       fetch_meta_i,
   input  logic                          fetch_exc_v_i,
   input  logic [exc_code_width_p-1:0]   fetch_exc_code_i,
   output logic                          fe_queue_v_o,
   input  logic                          fe_queue_ready_i,
   output logic [vaddr_width_p-1:0]      fe_queue_pc_o,
   output logic [instr_width_p-1:0]      fe_queue_instr_o,
   output logic [meta_width_p-1:0]       fe_queue_meta_o,
   output logic                          fe_queue_exc_v_o,
   output logic [exc_code_width_p-1:0]   fe_queue_exc_code_o,
   output logic [$clog2(els_p+1)-1:0]    count_o,
   output logic [1:0]                    state_o
);

   localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned cnt_width_lp = $clog2(els_p+1);
   localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p-1);
   localparam logic [cnt_width_lp-1:0] els_cnt_lp  = cnt_width_lp'(els_p);

   typedef enum logic [1:0] {e_wait = 2'd0, e_run = 2'd1, e_drain = 2'd2} state_e;

   state_e                        state_r;
   logic [ptr_width_lp-1:0]       wptr_r, rptr_r;
   logic [cnt_width_lp-1:0]       count_r;

   logic [vaddr_width_p-1:0]      pc_mem    [els_p];
   logic [instr_width_p-1:0]      instr_mem [els_p];
   logic [meta_width_p-1:0]       meta_mem  [els_p];
   logic                          exc_mem   [els_p];
   logic [exc_code_width_p-1:0]   code_mem  [els_p];

   logic empty, enq, deq, wr, pop;
   logic [instr_width_p-1:0] instr_in;
   logic [meta_width_p-1:0]  meta_in;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
   endfunction

   // Exception entries carry no instruction or metadata payload.
   assign instr_in = fetch_exc_v_i ? '0 : fetch_instr_i;
   assign meta_in  = fetch_exc_v_i ? '0 : fetch_meta_i;

   assign empty         = (count_r == '0);
   assign fetch_ready_o = ~reset_i & ~redirect_v_i & (state_r == e_run) & (count_r < els_cnt_lp);
   assign enq           = fetch_v_i & fetch_ready_o;

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
   logic byp_v;
   assign byp_v        = enq & empty;
   assign fe_queue_v_o = ~reset_i & (~empty | enq);
   assign wr           = enq & ~(empty & fe_queue_ready_i);
`else
   assign fe_queue_v_o = ~reset_i & ~empty;
   assign wr           = enq;
`endif

   assign deq = fe_queue_v_o & fe_queue_ready_i;
   assign pop = deq & ~empty;

   // Head presentation; zero whenever nothing is valid.
   always_comb begin
      fe_queue_pc_o       = '0;
      fe_queue_instr_o    = '0;
      fe_queue_meta_o     = '0;
      fe_queue_exc_v_o    = 1'b0;
      fe_queue_exc_code_o = '0;
      if (~reset_i & ~empty) begin
         fe_queue_pc_o       = pc_mem[rptr_r];
         fe_queue_instr_o    = instr_mem[rptr_r];
         fe_queue_meta_o     = meta_mem[rptr_r];
         fe_queue_exc_v_o    = exc_mem[rptr_r];
         fe_queue_exc_code_o = code_mem[rptr_r];
      end
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
      else if (byp_v) begin
         fe_queue_pc_o       = fetch_pc_i;
         fe_queue_instr_o    = instr_in;
         fe_queue_meta_o     = meta_in;
         fe_queue_exc_v_o    = fetch_exc_v_i;
         fe_queue_exc_code_o = fetch_exc_code_i;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (wr) begin
         pc_mem[wptr_r]    <= fetch_pc_i;
         instr_mem[wptr_r] <= instr_in;
         meta_mem[wptr_r]  <= meta_in;
         exc_mem[wptr_r]   <= fetch_exc_v_i;
         code_mem[wptr_r]  <= fetch_exc_code_i;
      end
   end

   // Pointers, occupancy and control state; redirect overrides everything but reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= e_wait;
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else if (redirect_v_i) begin
         state_r <= e_run;
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (wr)  wptr_r <= ptr_inc(wptr_r);
         if (pop) rptr_r <= ptr_inc(rptr_r);
         unique case ({wr, pop})
            2'b10:   count_r <= count_r + cnt_width_lp'(1);
            2'b01:   count_r <= count_r - cnt_width_lp'(1);
            default: count_r <= count_r;
         endcase
         unique case (state_r)
            e_wait:  state_r <= e_wait;
            // An exception consumed by the bypass leaves nothing to drain.
            e_run:   if (enq & fetch_exc_v_i) state_r <= wr ? e_drain : e_wait;
            e_drain: if (pop && count_r == cnt_width_lp'(1)) state_r <= e_wait;
            default: state_r <= e_wait;
         endcase
      end
   end

   assign count_o = count_r;
   assign state_o = state_r;

endmodule

// File: doc/bp_fe_fetch_buffer.md
Name: bp_fe_fetch_buffer

Overview:
- Parametrised decoupling buffer between the I$ TV-stage output and the FE queue.
- Generalises single-entry direct fetch/exception forwarding to an els_p-deep FIFO.
- Owns the fetch wait/run state machine and adds an explicit exception-drain state.
- Flushes on redirect so the PC generator can keep fetching while the BE stalls.

Parameters:
- vaddr_width_p, 39, virtual PC width.
- instr_width_p, 32, instruction width.
- meta_width_p, 36, branch metadata forward width.
- exc_code_width_p, 2, exception code width (itlb_miss / icache_miss / page_fault / access_fault).
- els_p, 4, entry count; any value ≥2, power of two not required.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- redirect_v_i  in  1  non-attaboy FE command accepted this cycle: flush and run
- fetch_v_i  in  1  I$/fault stage has an entry
- fetch_ready_o  out  1  buffer accepts entry this cycle
- fetch_pc_i  in  vaddr_width_p  entry PC
- fetch_instr_i  in  instr_width_p  instruction
- fetch_meta_i  in  meta_width_p  branch metadata
- fetch_exc_v_i  in  1  entry is an exception
- fetch_exc_code_i  in  exc_code_width_p  exception code
- fe_queue_v_o  out  1  head valid
- fe_queue_ready_i  in  1  FE queue accepts head
- fe_queue_pc_o  out  vaddr_width_p  head PC
- fe_queue_instr_o  out  instr_width_p  head instruction; 0 on exception entries
- fe_queue_meta_o  out  meta_width_p  head metadata; 0 on exception entries
- fe_queue_exc_v_o  out  1  head is an exception
- fe_queue_exc_code_o  out  exc_code_width_p  head exception code
- count_o  out  $clog2(els_p+1)  occupancy
- state_o  out  2  0=e_wait, 1=e_run, 2=e_drain

Behaviour:
- Clock is clk_i; reset is reset_i, synchronous and active-high. This is fixed.
- Reset values: state e_wait, pointers 0, count_o 0, fe_queue_v_o 0, fetch_ready_o 0, all data outputs 0.
- Enqueue condition: fetch_v_i & fetch_ready_o.
- fetch_ready_o = (state==e_run) & (count<els_p) & ~redirect_v_i. This is combinational.
- Dequeue condition: fe_queue_v_o & fe_queue_ready_i.
- fe_queue_v_o = (count!=0). Outputs are driven from the head entry register.
- Latency: enqueue to visible at head is 1 cycle; there is no bypass in the base build.
- When full, a simultaneous dequeue does not enable an enqueue: ready depends on registered count only.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Pointers wrap from els_p-1 to 0. Exactly one of count==0 / count==els_p marks empty / full.
- State transitions:
  - e_wait -> e_run on redirect_v_i.
  - e_run -> e_drain on an enqueue with fetch_exc_v_i=1. That exception entry is stored; no further enqueues are accepted.
  - e_drain -> e_run on redirect_v_i.
  - e_drain -> e_wait when count reaches 0 through dequeue of the exception entry, if no redirect has arrived.
  - Illegal state -> e_wait.
- redirect_v_i in any state:
  - Next cycle count=0, both pointers=0, state=e_run.
  - Any same-cycle enqueue is blocked, because ready is low.
  - A same-cycle dequeue still completes; the FE queue sees the handshake. The flush then discards the remainder.
- Redirect has priority over every other transition.
- Reset asserted mid-operation behaves identically to a fresh reset. Entries are discarded and no handshake is honoured in the reset cycle.

Optional Feature:
- BP_FE_FETCH_BUFFER_BYPASS_EN defined: when count==0 and an enqueue occurs, the entry appears on the fe_queue_* outputs in the same cycle with fe_queue_v_o=1.
  - If fe_queue_ready_i=1, the entry is consumed without being written and count stays 0.
  - fe_queue_v_o becomes a combinational function of fetch_v_i/fetch_ready_o.
- Undefined: no combinational path from fetch_* to fe_queue_*; 1-cycle minimum latency.

Test Plan:
- Reset, then redirect_v_i=1 for 1 cycle -> state_o 0->1, fetch_ready_o=1 the next cycle, count_o=0.
- In run, enqueue PCs 0x80000000/04/08/0C with fe_queue_ready_i=0 -> count_o=4 and fetch_ready_o=0. Then ready=1 -> PCs dequeue in order, one per cycle.
- els_p=3 build: 10 back-to-back enqueue+dequeue pairs -> PC order preserved across pointer wrap, count_o stays ≤3.
- Enqueue fetch with PC 0x100, then exception (code=1, PC 0x104) -> state_o=2, fetch_ready_o=0. After both dequeue, state_o=0 and the exception head shows exc_v=1, code=1.
- Fill to 3 entries, assert redirect_v_i with fe_queue_ready_i=1 -> one dequeue handshake that cycle, then count_o=0, state_o=1. A fetch_v_i in the redirect cycle is not stored.
- BYPASS_EN build: empty, enqueue PC 0x200 with fe_queue_ready_i=1 -> fe_queue_v_o=1 with pc 0x200 in the same cycle, count_o remains 0.
